mips_bus_arbiter: RTL and testbench
===================================

Name: mips_bus_arbiter

Overview:
- Shares the single memory bus (address/read/write/byteenable/writedata/readdata/waitrequest) between the CPU instruction-fetch port and the CPU data port.
- The memory and the harness RAM model see one master; each CPU port sees a private bus with its own waitrequest.
- Registered grant with parking; round-robin or fixed data priority.
- A stall watchdog flags a slave that never releases waitrequest.

Parameters:
- DATA_PRIORITY, 0: 0 = round-robin between ports; 1 = data port always wins a simultaneous request.
- MAX_WAIT, 255: consecutive slave-stalled cycles tolerated before stall_error sets; 8-bit counter, legal range 1..255.

Ports:
- clk  in  1  system clock, all state on posedge.
- reset  in  1  asynchronous, active-low reset.
- i_address  in  32  fetch-port byte address.
- i_read  in  1  fetch-port read request.
- i_write  in  1  fetch-port write request (normally 0; arbitrated identically).
- i_byteenable  in  4  fetch-port byte enables.
- i_writedata  in  32  fetch-port write data.
- i_readdata  out  32  fetch-port read data.
- i_waitrequest  out  1  fetch-port stall.
- d_address, d_read, d_write, d_byteenable, d_writedata  in  32/1/1/4/32  data-port equivalents.
- d_readdata  out  32  data-port read data.
- d_waitrequest  out  1  data-port stall.
- m_address, m_read, m_write, m_byteenable, m_writedata  out  32/1/1/4/32  to memory.
- m_readdata  in  32  from memory.
- m_waitrequest  in  1  memory stall.
- grant  out  2  one-hot registered owner: bit0 = fetch, bit1 = data.
- stall_error  out  1  sticky watchdog flag.

Behaviour:
- Port requests: req_i = i_read|i_write; req_d = d_read|d_write.
- A transfer completes in a cycle where the owner's request is high and m_waitrequest is 0. m_readdata is valid in that same cycle.
- States: IDLE, GNT_I, GNT_D. State, last-owner bit, stall counter and stall_error are registers; everything else is combinational from state.
- IDLE:
  - Memory outputs m_read = m_write = 0; other m_* outputs are 0.
  - Both waitrequests are 1.
  - On any request, the next state is the selected owner, so arbitration costs 1 cycle.
  - Selection: only one requester wins. If both request, DATA_PRIORITY = 1 selects D; otherwise the port not granted last wins. After reset, "last" = D, so I wins the first tie.
- GNT_x:
  - All m_* outputs mirror port x combinationally.
  - x_waitrequest = m_waitrequest. The other port's waitrequest = 1.
  - Both x_readdata outputs = m_readdata (broadcast; only meaningful to the owner).
- Leaving GNT_x: on completion, or when x has no request:
  - If the other port requests, move to GNT_other and update "last".
  - Otherwise remain in GNT_x (parked).
  - A parked owner that raises its request proceeds with 0 extra latency.
  - With DATA_PRIORITY = 1, a parked GNT_I whose request is high still yields to req_d only at completion, never mid-transfer.
- Mid-transfer preemption is forbidden: the owner's held request plus m_waitrequest = 1 keeps the grant.
- Watchdog:
  - The counter increments each cycle with the owner requesting and m_waitrequest = 1, saturating at MAX_WAIT. It clears on completion or on a grant change.
  - When the counter reaches MAX_WAIT, stall_error sets and stays set until reset. Arbitration is unaffected.
- Reset (asserted low, any time, including mid-transfer):
  - State goes to IDLE, grant = 00, last = D, counter = 0, stall_error = 0.
  - Memory outputs drop to 0 asynchronously; both waitrequests go to 1.
  - The aborted transfer is not resumed.
- grant = 01 in GNT_I, 10 in GNT_D, 00 in IDLE. It is never 11.

Decomposition:
- Package mips_bus_pkg:
  - enum arb_state_t {IDLE, GNT_I, GNT_D}.
  - GRANT_I = 2'b01, GRANT_D = 2'b10.
  - Bus width constants ADDR_W = 32, DATA_W = 32, BE_W = 4.
- Sub-module mips_bus_stall_wdog: counter plus sticky flag. Inputs: clk, reset, stalled, clear. Output: stall_error.
- Mux and FSM stay in the top module.

Test Plan:
- Reset hold then release, no requests -> grant = 00, m_read = 0, i_waitrequest = d_waitrequest = 1, stall_error = 0.
- Fetch-only read at 0x00000010, memory zero-wait returning 0x8C020004 -> cycle 1 IDLE (i_waitrequest = 1), cycle 2 grant = 01, m_address = 0x10, i_readdata = 0x8C020004, i_waitrequest = 0. Back-to-back fetch at 0x14 completes the next cycle (parked).
- Simultaneous i_read@0x20 and d_write@0x40, data 0xDEADBEEF, be = 1111, round-robin -> I is served first, then grant = 10 the cycle after I completes, m_writedata = 0xDEADBEEF. A repeat of both requests serves D first.
- DATA_PRIORITY = 1, both requesting continuously -> D is granted every arbitration; I stays stalled until d_read/d_write drop.
- Memory holds m_waitrequest = 1 for 3 cycles during a D read -> grant stays 10 despite req_i, d_waitrequest = 1 for 3 cycles, completion on cycle 4, then switch to I.
- MAX_WAIT = 4, m_waitrequest stuck at 1 -> stall_error rises after 4 stalled cycles and stays 1 after waitrequest clears. Reset asserted mid-transfer -> immediate IDLE, all outputs return to reset values.

Source files
------------

// File: rtl/mips_bus_pkg.sv
// Shared types and constants for the MIPS memory-bus arbiter.
//   arb_state_t      : arbiter FSM states
//   GRANT_I/GRANT_D  : one-hot grant encodings (bit0 = fetch, bit1 = data)
//   ADDR_W/DATA_W/BE_W : bus widths
package mips_bus_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int BE_W   = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2
    } arb_state_t;

    localparam logic [1:0] GRANT_I = 2'b01;
    localparam logic [1:0] GRANT_D = 2'b10;

endpackage

// File: rtl/mips_bus_stall_wdog.sv
// Stall watchdog: counts consecutive cycles the bus owner is held off by the
// slave and raises a sticky error once the count reaches MAX_WAIT.
//   clk         : system clock
//   reset       : asynchronous active-low reset
//   stalled     : owner requesting while the slave asserts waitrequest
//   clear       : transfer completed or ownership changed this cycle
//   stall_error : sticky flag, cleared only by reset
module mips_bus_stall_wdog #(
    parameter int MAX_WAIT = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic stalled,
    input  logic clear,
    output logic stall_error
);

    localparam logic [7:0] LIMIT = 8'(MAX_WAIT);

    logic [7:0] count;
    logic [7:0] count_inc;

    assign count_inc = count + 8'd1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count       <= '0;
            stall_error <= 1'b0;
        end else if (clear) begin
            count <= '0;
        end else if (stalled && (count != LIMIT)) begin
            count <= count_inc;
            // flag in the same edge the counter lands on the limit
            if (count_inc == LIMIT) begin
                stall_error <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/mips_bus_arbiter.sv
// Two-master arbiter sharing one memory bus between the CPU fetch port (i_*)
// and the CPU data port (d_*). Registered, parked grant; round-robin or fixed
// data priority on simultaneous requests; no preemption mid-transfer.
//   i_* / d_*   : private port buses (address/read/write/byteenable/
//                 writedata in, readdata/waitrequest out)
//   m_*         : shared memory bus
//   grant       : one-hot owner (bit0 fetch, bit1 data), 00 while idle
//   stall_error : sticky watchdog flag
//
// state | meaning
// IDLE  | no owner yet (only after reset); memory bus quiet, both ports stalled
// GNT_I | fetch port owns the bus (active or parked)
// GNT_D | data port owns the bus (active or parked)
module mips_bus_arbiter
    import mips_bus_pkg::*;
#(
    parameter int DATA_PRIORITY = 0,
    parameter int MAX_WAIT      = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] i_address,
    input  logic              i_read,
    input  logic              i_write,
    input  logic [BE_W-1:0]   i_byteenable,
    input  logic [DATA_W-1:0] i_writedata,
    output logic [DATA_W-1:0] i_readdata,
    output logic              i_waitrequest,
    input  logic [ADDR_W-1:0] d_address,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [BE_W-1:0]   d_byteenable,
    input  logic [DATA_W-1:0] d_writedata,
    output logic [DATA_W-1:0] d_readdata,
    output logic              d_waitrequest,
    output logic [ADDR_W-1:0] m_address,
    output logic              m_read,
    output logic              m_write,
    output logic [BE_W-1:0]   m_byteenable,
    output logic [DATA_W-1:0] m_writedata,
    input  logic [DATA_W-1:0] m_readdata,
    input  logic              m_waitrequest,
    output logic [1:0]        grant,
    output logic              stall_error
);

    arb_state_t state, state_next;
    logic       last_d;     // 1 when the data port was the most recent grantee
    logic       req_i, req_d, owner_req, done, stalled;

    assign req_i = i_read | i_write;
    assign req_d = d_read | d_write;

    always_comb begin
        owner_req = 1'b0;
        case (state)
            GNT_I:   owner_req = req_i;
            GNT_D:   owner_req = req_d;
            default: owner_req = 1'b0;
        endcase
    end

    assign done    = owner_req & ~m_waitrequest;
    assign stalled = owner_req &  m_waitrequest;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            last_d <= 1'b1;
        end else begin
            state <= state_next;
            if (state_next != state) begin
                last_d <= (state_next == GNT_D);
            end
        end
    end

    // Ownership only moves when the owner is free (completed or not asking);
    // a held request under waitrequest always keeps the bus.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (req_i && req_d) begin
                    state_next = ((DATA_PRIORITY != 0) || !last_d) ? GNT_D : GNT_I;
                end else if (req_i) begin
                    state_next = GNT_I;
                end else if (req_d) begin
                    state_next = GNT_D;
                end
            end
            GNT_I: begin
                if (req_d && (!req_i || done)) begin
                    state_next = GNT_D;
                end
            end
            GNT_D: begin
                // with data priority a still-requesting data port keeps the bus
                if (req_i && (!req_d || (done && (DATA_PRIORITY == 0)))) begin
                    state_next = GNT_I;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        m_address     = '0;
        m_read        = 1'b0;
        m_write       = 1'b0;
        m_byteenable  = '0;
        m_writedata   = '0;
        i_readdata    = '0;
        d_readdata    = '0;
        i_waitrequest = 1'b1;
        d_waitrequest = 1'b1;
        grant         = 2'b00;
        case (state)
            GNT_I: begin
                m_address     = i_address;
                m_read        = i_read;
                m_write       = i_write;
                m_byteenable  = i_byteenable;
                m_writedata   = i_writedata;
                i_readdata    = m_readdata;
                d_readdata    = m_readdata;
                i_waitrequest = m_waitrequest;
                grant         = GRANT_I;
            end
            GNT_D: begin
                m_address     = d_address;
                m_read        = d_read;
                m_write       = d_write;
                m_byteenable  = d_byteenable;
                m_writedata   = d_writedata;
                i_readdata    = m_readdata;
                d_readdata    = m_readdata;
                d_waitrequest = m_waitrequest;
                grant         = GRANT_D;
            end
            default: ;
        endcase
    end

    mips_bus_stall_wdog #(
        .MAX_WAIT (MAX_WAIT)
    ) u_wdog (
        .clk         (clk),
        .reset       (reset),
        .stalled     (stalled),
        .clear       (done | (state_next != state)),
        .stall_error (stall_error)
    );

endmodule

// File: tb/tb_mips_bus_arbiter.sv
// Bench for mips_bus_arbiter: one round-robin instance (MAX_WAIT = 4) and one
// data-priority instance (MAX_WAIT = 255) share the same stimulus. A
// rule-level ownership model predicts every output of both each cycle.
module tb_mips_bus_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] i_address = '0, d_address = '0, i_writedata = '0, d_writedata = '0;
    logic        i_read = 1'b0, i_write = 1'b0, d_read = 1'b0, d_write = 1'b0;
    logic [3:0]  i_byteenable = 4'hF, d_byteenable = 4'hF;
    logic [31:0] m_readdata = '0;
    logic        m_waitrequest = 1'b0;

    logic [31:0] i_readdata [2];
    logic [31:0] d_readdata [2];
    logic        i_waitrequest [2];
    logic        d_waitrequest [2];
    logic [31:0] m_address [2];
    logic        m_read [2];
    logic        m_write [2];
    logic [3:0]  m_byteenable [2];
    logic [31:0] m_writedata [2];
    logic [1:0]  grant [2];
    logic        stall_error [2];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mips_bus_arbiter #(.DATA_PRIORITY(0), .MAX_WAIT(4)) dut_rr (
        .clk(clk), .reset(reset),
        .i_address(i_address), .i_read(i_read), .i_write(i_write),
        .i_byteenable(i_byteenable), .i_writedata(i_writedata),
        .i_readdata(i_readdata[0]), .i_waitrequest(i_waitrequest[0]),
        .d_address(d_address), .d_read(d_read), .d_write(d_write),
        .d_byteenable(d_byteenable), .d_writedata(d_writedata),
        .d_readdata(d_readdata[0]), .d_waitrequest(d_waitrequest[0]),
        .m_address(m_address[0]), .m_read(m_read[0]), .m_write(m_write[0]),
        .m_byteenable(m_byteenable[0]), .m_writedata(m_writedata[0]),
        .m_readdata(m_readdata), .m_waitrequest(m_waitrequest),
        .grant(grant[0]), .stall_error(stall_error[0])
    );

    mips_bus_arbiter #(.DATA_PRIORITY(1), .MAX_WAIT(255)) dut_dp (
        .clk(clk), .reset(reset),
        .i_address(i_address), .i_read(i_read), .i_write(i_write),
        .i_byteenable(i_byteenable), .i_writedata(i_writedata),
        .i_readdata(i_readdata[1]), .i_waitrequest(i_waitrequest[1]),
        .d_address(d_address), .d_read(d_read), .d_write(d_write),
        .d_byteenable(d_byteenable), .d_writedata(d_writedata),
        .d_readdata(d_readdata[1]), .d_waitrequest(d_waitrequest[1]),
        .m_address(m_address[1]), .m_read(m_read[1]), .m_write(m_write[1]),
        .m_byteenable(m_byteenable[1]), .m_writedata(m_writedata[1]),
        .m_readdata(m_readdata), .m_waitrequest(m_waitrequest),
        .grant(grant[1]), .stall_error(stall_error[1])
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model: owner 0 = nobody, 1 = fetch, 2 = data
    int mdl_own [2];
    int mdl_last [2];
    int mdl_cnt [2];
    bit mdl_err [2];
    int mdl_max [2] = '{4, 255};
    bit mdl_dp [2]  = '{1'b0, 1'b1};

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            mdl_own[k] = 0; mdl_last[k] = 2; mdl_cnt[k] = 0; mdl_err[k] = 1'b0;
        end
    endtask

    function automatic int next_owner(int own, int last, bit ri, bit rd, bit wt, bit dp);
        bit mine, theirs;
        if (own == 0) begin
            if (ri && rd) return dp ? 2 : ((last == 2) ? 1 : 2);
            if (ri) return 1;
            if (rd) return 2;
            return 0;
        end
        mine   = (own == 1) ? ri : rd;
        theirs = (own == 1) ? rd : ri;
        if (mine && wt) return own;            // transfer in flight: no preemption
        if (!theirs) return own;               // nobody else wants it: stay parked
        if (dp && own == 2 && rd) return own;  // data port still asking keeps priority
        return 3 - own;
    endfunction

    task automatic model_advance();
        bit ri, rd, mine;
        int nxt;
        ri = i_read | i_write;
        rd = d_read | d_write;
        for (int k = 0; k < 2; k++) begin
            nxt  = next_owner(mdl_own[k], mdl_last[k], ri, rd, m_waitrequest, mdl_dp[k]);
            mine = (mdl_own[k] == 1) ? ri : (mdl_own[k] == 2) ? rd : 1'b0;
            if (nxt != mdl_own[k] || (mine && !m_waitrequest)) begin
                mdl_cnt[k] = 0;
            end else if (mine && m_waitrequest) begin
                if (mdl_cnt[k] < mdl_max[k]) mdl_cnt[k]++;
                if (mdl_cnt[k] == mdl_max[k]) mdl_err[k] = 1'b1;
            end
            if (nxt != mdl_own[k]) mdl_last[k] = nxt;
            mdl_own[k] = nxt;
        end
    endtask

    task automatic model_check();
        logic [1:0] eg; logic [31:0] ea, ewd, erd; logic er, ew, eiw, edw; logic [3:0] ebe;
        for (int k = 0; k < 2; k++) begin
            eg = 2'b00; ea = '0; ewd = '0; erd = '0; er = 0; ew = 0; ebe = '0; eiw = 1; edw = 1;
            if (mdl_own[k] == 1) begin
                eg = 2'b01; ea = i_address; er = i_read; ew = i_write; ebe = i_byteenable;
                ewd = i_writedata; erd = m_readdata; eiw = m_waitrequest;
            end else if (mdl_own[k] == 2) begin
                eg = 2'b10; ea = d_address; er = d_read; ew = d_write; ebe = d_byteenable;
                ewd = d_writedata; erd = m_readdata; edw = m_waitrequest;
            end
            chk($sformatf("grant[%0d]", k), 32'(grant[k]), 32'(eg));
            chk($sformatf("m_address[%0d]", k), m_address[k], ea);
            chk($sformatf("m_read[%0d]", k), 32'(m_read[k]), 32'(er));
            chk($sformatf("m_write[%0d]", k), 32'(m_write[k]), 32'(ew));
            chk($sformatf("m_byteenable[%0d]", k), 32'(m_byteenable[k]), 32'(ebe));
            chk($sformatf("m_writedata[%0d]", k), m_writedata[k], ewd);
            chk($sformatf("i_readdata[%0d]", k), i_readdata[k], erd);
            chk($sformatf("d_readdata[%0d]", k), d_readdata[k], erd);
            chk($sformatf("i_waitrequest[%0d]", k), 32'(i_waitrequest[k]), 32'(eiw));
            chk($sformatf("d_waitrequest[%0d]", k), 32'(d_waitrequest[k]), 32'(edw));
            chk($sformatf("stall_error[%0d]", k), 32'(stall_error[k]), 32'(mdl_err[k]));
        end
    endtask

    // called at posedge+3 with inputs stable; returns at next posedge+1
    task automatic finish_cycle();
        model_check();
        @(posedge clk);
        model_advance();
        #1;
    endtask

    // reset asserted between edges; outputs must drop at once
    task automatic do_reset();
        reset = 1'b0;
        #1;
        model_reset();
        model_check();
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    // ---------------- directed table (expected values for the round-robin DUT)
    typedef struct {
        logic ri, iwr, rd, dwr;
        logic [31:0] ia, da, wd;
        logic wt;
        logic [31:0] rdata;
        logic [1:0] e_grant;
        logic e_iw, e_dw;
        logic [31:0] e_maddr, e_mwd;
        logic e_se;
    } vec_t;

    vec_t vecs [20];

    function automatic vec_t mk(logic ri, logic iwr, logic rd, logic dwr,
                                logic [31:0] ia, logic [31:0] da, logic [31:0] wd,
                                logic wt, logic [31:0] rdata, logic [1:0] eg,
                                logic eiw, logic edw, logic [31:0] ema,
                                logic [31:0] emwd, logic ese);
        vec_t v;
        v.ri = ri; v.iwr = iwr; v.rd = rd; v.dwr = dwr; v.ia = ia; v.da = da; v.wd = wd;
        v.wt = wt; v.rdata = rdata; v.e_grant = eg; v.e_iw = eiw; v.e_dw = edw;
        v.e_maddr = ema; v.e_mwd = emwd; v.e_se = ese;
        return v;
    endfunction

    initial begin
        int stall_run;
        //             ri iw rd dw  i_addr d_addr  wdata         wt rdata          grant  iw dw m_addr  m_wdata       se
        vecs[0]  = mk(0, 0, 0, 0, 32'h00, 32'h00, 32'h0,        0, 32'h0,        2'b00, 1, 1, 32'h00, 32'h0,        0);
        vecs[1]  = mk(1, 0, 0, 0, 32'h10, 32'h00, 32'h0,        0, 32'h8C020004, 2'b00, 1, 1, 32'h00, 32'h0,        0);
        vecs[2]  = mk(1, 0, 0, 0, 32'h10, 32'h00, 32'h0,        0, 32'h8C020004, 2'b01, 0, 1, 32'h10, 32'h0,        0);
        vecs[3]  = mk(1, 0, 0, 0, 32'h14, 32'h00, 32'h0,        0, 32'h8C020008, 2'b01, 0, 1, 32'h14, 32'h0,        0);
        vecs[4]  = mk(1, 0, 0, 1, 32'h20, 32'h40, 32'hDEADBEEF, 0, 32'h11111111, 2'b01, 0, 1, 32'h20, 32'h0,        0);
        vecs[5]  = mk(0, 0, 0, 1, 32'h20, 32'h40, 32'hDEADBEEF, 0, 32'h0,        2'b10, 1, 0, 32'h40, 32'hDEADBEEF, 0);
        vecs[6]  = mk(1, 0, 0, 1, 32'h24, 32'h44, 32'hCAFEF00D, 0, 32'h0,        2'b10, 1, 0, 32'h44, 32'hCAFEF00D, 0);
        vecs[7]  = mk(1, 0, 0, 0, 32'h24, 32'h44, 32'h0,        0, 32'h22222222, 2'b01, 0, 1, 32'h24, 32'h0,        0);
        vecs[8]  = mk(0, 0, 1, 0, 32'h28, 32'h80, 32'h0,        0, 32'h0,        2'b01, 0, 1, 32'h28, 32'h0,        0);
        vecs[9]  = mk(1, 0, 1, 0, 32'h28, 32'h80, 32'h0,        1, 32'h0,        2'b10, 1, 1, 32'h80, 32'h0,        0);
        vecs[10] = mk(1, 0, 1, 0, 32'h28, 32'h80, 32'h0,        1, 32'h0,        2'b10, 1, 1, 32'h80, 32'h0,        0);
        vecs[11] = mk(1, 0, 1, 0, 32'h28, 32'h80, 32'h0,        1, 32'h0,        2'b10, 1, 1, 32'h80, 32'h0,        0);
        vecs[12] = mk(1, 0, 1, 0, 32'h28, 32'h80, 32'h0,        0, 32'h33333333, 2'b10, 1, 0, 32'h80, 32'h0,        0);
        vecs[13] = mk(1, 0, 0, 0, 32'h28, 32'h80, 32'h0,        0, 32'h44444444, 2'b01, 0, 1, 32'h28, 32'h0,        0);
        vecs[14] = mk(1, 0, 0, 0, 32'h2C, 32'h00, 32'h0,        1, 32'h0,        2'b01, 1, 1, 32'h2C, 32'h0,        0);
        vecs[15] = mk(1, 0, 0, 0, 32'h2C, 32'h00, 32'h0,        1, 32'h0,        2'b01, 1, 1, 32'h2C, 32'h0,        0);
        vecs[16] = mk(1, 0, 0, 0, 32'h2C, 32'h00, 32'h0,        1, 32'h0,        2'b01, 1, 1, 32'h2C, 32'h0,        0);
        vecs[17] = mk(1, 0, 0, 0, 32'h2C, 32'h00, 32'h0,        1, 32'h0,        2'b01, 1, 1, 32'h2C, 32'h0,        0);
        vecs[18] = mk(1, 0, 0, 0, 32'h2C, 32'h00, 32'h0,        0, 32'h55555555, 2'b01, 0, 1, 32'h2C, 32'h0,        1);
        vecs[19] = mk(0, 0, 0, 0, 32'h2C, 32'h00, 32'h0,        0, 32'h0,        2'b01, 0, 1, 32'h2C, 32'h0,        1);

        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_grant", 32'(grant[0]), 32'h0);
        chk("reset_m_read", 32'(m_read[0]), 32'h0);
        chk("reset_i_wait", 32'(i_waitrequest[0]), 32'h1);
        chk("reset_d_wait", 32'(d_waitrequest[0]), 32'h1);
        reset = 1'b1;

        for (int n = 0; n < 20; n++) begin
            i_read = vecs[n].ri; i_write = vecs[n].iwr; d_read = vecs[n].rd; d_write = vecs[n].dwr;
            i_address = vecs[n].ia; d_address = vecs[n].da; d_writedata = vecs[n].wd;
            i_writedata = '0; i_byteenable = 4'hF; d_byteenable = 4'hF;
            m_waitrequest = vecs[n].wt; m_readdata = vecs[n].rdata;
            #2;
            chk($sformatf("vec%0d_grant", n), 32'(grant[0]), 32'(vecs[n].e_grant));
            chk($sformatf("vec%0d_i_wait", n), 32'(i_waitrequest[0]), 32'(vecs[n].e_iw));
            chk($sformatf("vec%0d_d_wait", n), 32'(d_waitrequest[0]), 32'(vecs[n].e_dw));
            chk($sformatf("vec%0d_m_address", n), m_address[0], vecs[n].e_maddr);
            chk($sformatf("vec%0d_m_writedata", n), m_writedata[0], vecs[n].e_mwd);
            chk($sformatf("vec%0d_stall_error", n), 32'(stall_error[0]), 32'(vecs[n].e_se));
            if (vecs[n].e_grant == 2'b01)
                chk($sformatf("vec%0d_i_readdata", n), i_readdata[0], vecs[n].rdata);
            finish_cycle();
        end

        // reset in the middle of a stalled fetch
        i_read = 1'b1; d_read = 1'b1; m_waitrequest = 1'b1;
        #2;
        finish_cycle();
        reset = 1'b0;
        #1;
        chk("midreset_grant_rr", 32'(grant[0]), 32'h0);
        chk("midreset_grant_dp", 32'(grant[1]), 32'h0);
        chk("midreset_m_read", 32'(m_read[0]), 32'h0);
        chk("midreset_m_address", m_address[0], 32'h0);
        chk("midreset_i_wait", 32'(i_waitrequest[0]), 32'h1);
        chk("midreset_d_wait", 32'(d_waitrequest[1]), 32'h1);
        chk("midreset_stall_error", 32'(stall_error[0]), 32'h0);
        model_reset();
        @(posedge clk);
        #1;
        i_read = 1'b0; d_read = 1'b0; m_waitrequest = 1'b0;
        reset = 1'b1;
        #2;
        chk("postreset_grant", 32'(grant[0]), 32'h0);
        finish_cycle();

        // both ports requesting continuously, zero-wait memory
        i_read = 1'b1; d_read = 1'b1; i_address = 32'h100; d_address = 32'h200;
        for (int n = 0; n < 6; n++) begin
            #2;
            chk($sformatf("tie%0d_grant_rr", n), 32'(grant[0]),
                (n == 0) ? 32'h0 : ((n % 2) == 1) ? 32'h1 : 32'h2);
            chk($sformatf("tie%0d_grant_dp", n), 32'(grant[1]), (n == 0) ? 32'h0 : 32'h2);
            chk($sformatf("tie%0d_i_wait_dp", n), 32'(i_waitrequest[1]), 32'h1);
            finish_cycle();
        end
        d_read = 1'b0;
        #2;
        chk("dp_release_grant", 32'(grant[1]), 32'h2);
        finish_cycle();
        #2;
        chk("dp_switch_grant", 32'(grant[1]), 32'h1);
        chk("dp_switch_i_wait", 32'(i_waitrequest[1]), 32'h0);
        finish_cycle();

        // randomized traffic against the model
        stall_run = 0;
        for (int n = 0; n < 3000; n++) begin
            int r;
            r = $urandom_range(0, 9);
            i_read = (r < 5); i_write = (r == 5);
            r = $urandom_range(0, 9);
            d_read = (r < 3); d_write = (r == 3 || r == 4);
            i_address = $urandom; d_address = $urandom;
            i_writedata = $urandom; d_writedata = $urandom;
            i_byteenable = 4'($urandom); d_byteenable = 4'($urandom);
            m_readdata = $urandom;
            if (stall_run == 0 && $urandom_range(0, 49) == 0) stall_run = $urandom_range(3, 8);
            if (stall_run > 0) begin
                m_waitrequest = 1'b1;
                stall_run--;
            end else begin
                m_waitrequest = ($urandom_range(0, 3) == 0);
            end
            if ($urandom_range(0, 299) == 0) begin
                do_reset();
            end else begin
                #2;
                finish_cycle();
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
